// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size, FSM state, RISC-V funct3 codes.
// No logic of its own; size_bytes() gives the byte count for an access size.
// Imported by lsu_align and load_store_unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_WR0,
    S_RD1,
    S_WR1,
    S_RESP
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic [2:0] size_bytes(input size_e sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for loads (extract + extend) and sub-word stores (merge).
// Latency: purely combinational. Backpressure: none, no state.
// Ports: lo_word/hi_word/off/size/is_unsigned -> load_data; old_word/wdata/off/size/part -> merged, lane_mask.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int REG_BITS = 32
) (
  input  logic [REG_BITS-1:0]   lo_word,
  input  logic [REG_BITS-1:0]   hi_word,
  input  logic [1:0]            off,
  input  size_e                 size,
  input  logic                  is_unsigned,
  input  logic [REG_BITS-1:0]   old_word,
  input  logic [REG_BITS-1:0]   wdata,
  input  logic                  part,
  output logic [REG_BITS-1:0]   load_data,
  output logic [REG_BITS-1:0]   merged,
  output logic [REG_BITS/8-1:0] lane_mask
);

  localparam int LANES = REG_BITS / 8;
  localparam int PW    = 2 * LANES;

  logic [2*REG_BITS-1:0] pair;
  logic [2*REG_BITS-1:0] data2;
  logic [PW-1:0]         size_mask;
  logic [PW-1:0]         mask2;
  logic [REG_BITS-1:0]   dsel;

  // Loads: treat {hi,lo} as one little-endian window and slide it down to the offset.
  always_comb begin
    pair = {hi_word, lo_word} >> {off, 3'b000};
    case (size)
      SZ_B:    load_data = is_unsigned ? REG_BITS'(pair[7:0])
                                       : {{(REG_BITS-8){pair[7]}}, pair[7:0]};
      SZ_H:    load_data = is_unsigned ? REG_BITS'(pair[15:0])
                                       : {{(REG_BITS-16){pair[15]}}, pair[15:0]};
      default: load_data = pair[REG_BITS-1:0];
    endcase
  end

  // Stores: lanes laid out across two words; part picks which word is being rewritten.
  always_comb begin
    case (size)
      SZ_B:    size_mask = PW'(1);
      SZ_H:    size_mask = PW'(3);
      default: size_mask = PW'(15);
    endcase
    mask2     = size_mask << off;
    data2     = {{REG_BITS{1'b0}}, wdata} << {off, 3'b000};
    lane_mask = part ? mask2[PW-1:LANES] : mask2[LANES-1:0];
    dsel      = part ? data2[2*REG_BITS-1:REG_BITS] : data2[REG_BITS-1:0];
    merged    = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (lane_mask[i]) merged[i*8 +: 8] = dsel[i*8 +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW onto a word-wide DataMemory port.
// Latency accept->resp_valid: aligned load 2, word store 2, sub-word store 3, crossing load 3, crossing store 5, error 1.
// Backpressure: req_ready high only in IDLE; one request in flight, request inputs ignored while busy.
// Build option LSU_MISALIGN_EN: word-crossing accesses are split over two words; undefined, misaligned
// accesses return resp_err with no memory write and the second-word states are not built.
// Ports: CLK/RST (async active-high); req_* core request; resp_* one-cycle response;
//        mem_addr/mem_wd/mem_we to DataMemory, mem_rd combinational read data back.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int REG_BITS      = 32,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [REG_BITS-1:0]      req_addr,
  input  logic [REG_BITS-1:0]      req_wdata,
  output logic                     resp_valid,
  output logic [REG_BITS-1:0]      resp_rdata,
  output logic                     resp_err,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [REG_BITS-1:0]      mem_wd,
  output logic                     mem_we,
  input  logic [REG_BITS-1:0]      mem_rd
);

  state_e                   state;
  logic                     we_q;
  logic [2:0]               f3_q;
  logic [1:0]               off_q;
  logic [MEM_ADDR_BITS-1:0] word0_q;
  logic [REG_BITS-1:0]      wdata_q;

  size_e                    req_size;
  size_e                    sz_q;
  logic [1:0]               req_off;
  logic [MEM_ADDR_BITS-1:0] req_word0;
  logic                     req_err;
  logic                     req_full_word;

  assign req_off       = req_addr[1:0];
  assign req_word0     = req_addr[MEM_ADDR_BITS+1:2];
  assign req_size      = size_e'(req_funct3[1:0]);
  assign sz_q          = size_e'(f3_q[1:0]);
  assign req_full_word = (req_size == SZ_W) && (req_off == 2'd0);

  // Address bits above the memory window alias; they are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[REG_BITS-1:MEM_ADDR_BITS+2];

`ifdef LSU_MISALIGN_EN
  logic                     cross_q;
  logic                     req_cross;
  logic [2:0]               req_end;
  logic [REG_BITS-1:0]      lo_q;
  logic [MEM_ADDR_BITS-1:0] word1;

  assign req_end   = {1'b0, req_off} + size_bytes(req_size);
  assign req_cross = (req_end > 3'd4);
  assign req_err   = (req_funct3[1:0] == 2'b11);
  assign word1     = word0_q + 1'b1;  // wraps at the top of memory
`else
  assign req_err = (req_funct3[1:0] == 2'b11)
                || ((req_size == SZ_H) && req_off[0])
                || ((req_size == SZ_W) && (req_off != 2'd0));
`endif

  logic [REG_BITS-1:0]   align_lo;
  logic                  align_part;
  logic [REG_BITS-1:0]   load_data;
  logic [REG_BITS-1:0]   merged;
  logic [REG_BITS/8-1:0] unused_lane_mask;

  // In RD1 the low word was captured in RD0 and mem_rd now carries the high word.
`ifdef LSU_MISALIGN_EN
  assign align_lo   = (state == S_RD1) ? lo_q : mem_rd;
  assign align_part = (state == S_RD1);
`else
  assign align_lo   = mem_rd;
  assign align_part = 1'b0;
`endif

  lsu_align #(.REG_BITS(REG_BITS)) u_align (
    .lo_word     (align_lo),
    .hi_word     (mem_rd),
    .off         (off_q),
    .size        (sz_q),
    .is_unsigned (f3_q[2]),
    .old_word    (mem_rd),
    .wdata       (wdata_q),
    .part        (align_part),
    .load_data   (load_data),
    .merged      (merged),
    .lane_mask   (unused_lane_mask)
  );

  // All outputs are registered: each transition sets up the memory port for the state being entered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wd     <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      word0_q    <= '0;
      wdata_q    <= '0;
`ifdef LSU_MISALIGN_EN
      cross_q    <= 1'b0;
      lo_q       <= '0;
`endif
    end else begin
      mem_we     <= 1'b0;
      mem_wd     <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            f3_q      <= req_funct3;
            off_q     <= req_off;
            word0_q   <= req_word0;
            wdata_q   <= req_wdata;
            mem_addr  <= req_word0;
`ifdef LSU_MISALIGN_EN
            cross_q   <= req_cross;
`endif
            if (req_err) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_we && req_full_word) begin
              state  <= S_WR0;
              mem_we <= 1'b1;
              mem_wd <= req_wdata;
            end else begin
              state <= S_RD0;
            end
          end
        end
        S_RD0: begin
          if (we_q) begin
            state  <= S_WR0;
            mem_we <= 1'b1;
            mem_wd <= merged;
          end else begin
`ifdef LSU_MISALIGN_EN
            if (cross_q) begin
              state    <= S_RD1;
              lo_q     <= mem_rd;
              mem_addr <= word1;
            end else
`endif
            begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= load_data;
            end
          end
        end
        S_WR0: begin
`ifdef LSU_MISALIGN_EN
          if (cross_q) begin
            state    <= S_RD1;
            mem_addr <= word1;
          end else
`endif
          begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
          end
        end
`ifdef LSU_MISALIGN_EN
        S_RD1: begin
          if (we_q) begin
            state  <= S_WR1;
            mem_we <= 1'b1;
            mem_wd <= merged;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
            mem_addr   <= word0_q;
          end
        end
        S_WR1: begin
          state      <= S_RESP;
          resp_valid <= 1'b1;
          mem_addr   <= word0_q;
        end
`endif
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-array DataMemory model (combinational read).
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  load_store_unit dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // DataMemory model; bench preloads go through the same write process.
  logic [31:0] mem [1024];
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;
  assign mem_rd = mem[mem_addr];
  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wd;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_rdy1;
  int          r_lat;
  int          r_wecnt;
  logic [9:0]  r_wa [2];
  logic [31:0] r_wd [2];

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge CLK);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge CLK);
    #1 pl_en = 1'b0;
  endtask

  task automatic start_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge CLK);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge CLK);
    #1 req_valid = 1'b0;
  endtask

  // Issues one request and records latency (cycles after the accept edge), response and memory writes.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    start_req(we, f3, addr, wd);
    r_lat = -1; r_wecnt = 0; r_rdata = '0; r_err = 1'b0; r_rdy1 = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (c == 1) r_rdy1 = req_ready;
      if (mem_we) begin
        if (r_wecnt < 2) begin r_wa[r_wecnt] = mem_addr; r_wd[r_wecnt] = mem_wd; end
        r_wecnt++;
      end
      if (resp_valid) begin r_lat = c; r_rdata = resp_rdata; r_err = resp_err; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 10'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_wd !== 32'h0) begin errors++; $display("FAIL reset_mem_wd: got %h expected 0", mem_wd); end
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_resp_valid: got %b expected 0", resp_valid); end
  endtask

  task automatic test_load();
    logic [2:0]  f3s   [8] = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW, F3_LB, F3_LBU, F3_LW};
    logic [31:0] adrs  [8] = '{32'h41, 32'h41, 32'h42, 32'h42, 32'h40, 32'h43, 32'h40, 32'h1000_0040};
    logic [31:0] exp_d [8] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899, 32'h0000_8899,
                               32'h8899_AABB, 32'hFFFF_FF88, 32'h0000_00BB, 32'h8899_AABB};
    poke(10'h010, 32'h8899_AABB);
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, f3s[i], adrs[i], 32'h0);
      checks++; if (r_rdata !== exp_d[i]) begin errors++; $display("FAIL load%0d_rdata: got %h expected %h", i, r_rdata, exp_d[i]); end
      checks++; if (r_lat !== 2) begin errors++; $display("FAIL load%0d_latency: got %0d expected 2", i, r_lat); end
      checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL load%0d_err: got %b expected 0", i, r_err); end
      checks++; if (r_wecnt !== 0) begin errors++; $display("FAIL load%0d_writes: got %0d expected 0", i, r_wecnt); end
      checks++; if (r_rdy1 !== 1'b0) begin errors++; $display("FAIL load%0d_busy_ready: got %b expected 0", i, r_rdy1); end
    end
  endtask

  task automatic test_store();
    do_req(1'b1, F3_SB, 32'h42, 32'h0000_005C);
    checks++; if (r_lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d expected 3", r_lat); end
    checks++; if (r_wecnt !== 1) begin errors++; $display("FAIL sb_writes: got %0d expected 1", r_wecnt); end
    checks++; if (r_wa[0] !== 10'h010) begin errors++; $display("FAIL sb_mem_addr: got %h expected 010", r_wa[0]); end
    checks++; if (r_wd[0] !== 32'h885C_AABB) begin errors++; $display("FAIL sb_mem_wd: got %h expected 885caabb", r_wd[0]); end
    checks++; if (r_rdata !== 32'h0) begin errors++; $display("FAIL sb_rdata: got %h expected 0", r_rdata); end
    do_req(1'b1, F3_SH, 32'h40, 32'hFFFF_1234);
    checks++; if (mem[16] !== 32'h885C_1234) begin errors++; $display("FAIL sh_word: got %h expected 885c1234", mem[16]); end
    checks++; if (r_lat !== 3) begin errors++; $display("FAIL sh_latency: got %0d expected 3", r_lat); end
    do_req(1'b1, F3_SB, 32'h43, 32'h1234_56A7);
    checks++; if (mem[16] !== 32'hA75C_1234) begin errors++; $display("FAIL sb_top_lane: got %h expected a75c1234", mem[16]); end
    do_req(1'b1, F3_SW, 32'h48, 32'hDEAD_BEEF);
    checks++; if (r_lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", r_lat); end
    checks++; if (r_wecnt !== 1) begin errors++; $display("FAIL sw_writes: got %0d expected 1", r_wecnt); end
    checks++; if (r_wa[0] !== 10'h012) begin errors++; $display("FAIL sw_mem_addr: got %h expected 012", r_wa[0]); end
    checks++; if (mem[18] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_word: got %h expected deadbeef", mem[18]); end
    do_req(1'b1, F3_SW, 32'hFFFF_F04C, 32'h0BAD_F00D);
    checks++; if (mem[19] !== 32'h0BAD_F00D) begin errors++; $display("FAIL sw_alias: got %h expected 0badf00d", mem[19]); end
  endtask

  task automatic test_error();
    do_req(1'b0, 3'b011, 32'h40, 32'h0);
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL illegal_ld_err: got %b expected 1", r_err); end
    checks++; if (r_rdata !== 32'h0) begin errors++; $display("FAIL illegal_ld_rdata: got %h expected 0", r_rdata); end
    checks++; if (r_lat !== 1) begin errors++; $display("FAIL illegal_ld_latency: got %0d expected 1", r_lat); end
    do_req(1'b1, 3'b111, 32'h48, 32'h0);
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL illegal_st_err: got %b expected 1", r_err); end
    checks++; if (r_wecnt !== 0) begin errors++; $display("FAIL illegal_st_writes: got %0d expected 0", r_wecnt); end
    checks++; if (mem[18] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL illegal_st_word: got %h expected deadbeef", mem[18]); end
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_EN
    poke(10'h010, 32'h4433_2211);
    poke(10'h011, 32'h8877_6655);
    do_req(1'b0, F3_LW, 32'h43, 32'h0);
    checks++; if (r_rdata !== 32'h7766_5544) begin errors++; $display("FAIL xlw_rdata: got %h expected 77665544", r_rdata); end
    checks++; if (r_lat !== 3) begin errors++; $display("FAIL xlw_latency: got %0d expected 3", r_lat); end
    do_req(1'b0, F3_LW, 32'h41, 32'h0);
    checks++; if (r_rdata !== 32'h5544_3322) begin errors++; $display("FAIL xlw1_rdata: got %h expected 55443322", r_rdata); end
    do_req(1'b0, F3_LH, 32'h43, 32'h0);
    checks++; if (r_rdata !== 32'h0000_5544) begin errors++; $display("FAIL xlh_rdata: got %h expected 00005544", r_rdata); end
    do_req(1'b1, F3_SH, 32'h43, 32'h0000_BEEF);
    checks++; if (r_lat !== 5) begin errors++; $display("FAIL xsh_latency: got %0d expected 5", r_lat); end
    checks++; if (r_wecnt !== 2) begin errors++; $display("FAIL xsh_writes: got %0d expected 2", r_wecnt); end
    checks++; if (r_wa[0] !== 10'h010 || r_wa[1] !== 10'h011) begin errors++; $display("FAIL xsh_addrs: got %h,%h expected 010,011", r_wa[0], r_wa[1]); end
    checks++; if (mem[16] !== 32'hEF33_2211) begin errors++; $display("FAIL xsh_word0: got %h expected ef332211", mem[16]); end
    checks++; if (mem[17] !== 32'h8877_66BE) begin errors++; $display("FAIL xsh_word1: got %h expected 887766be", mem[17]); end
`else
    poke(10'h010, 32'h4433_2211);
    do_req(1'b0, F3_LW, 32'h43, 32'h0);
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL mislw_err: got %b expected 1", r_err); end
    checks++; if (r_rdata !== 32'h0) begin errors++; $display("FAIL mislw_rdata: got %h expected 0", r_rdata); end
    checks++; if (r_lat !== 1) begin errors++; $display("FAIL mislw_latency: got %0d expected 1", r_lat); end
    checks++; if (r_wecnt !== 0) begin errors++; $display("FAIL mislw_writes: got %0d expected 0", r_wecnt); end
    do_req(1'b1, F3_SH, 32'h41, 32'h0000_BEEF);
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL missh_err: got %b expected 1", r_err); end
    checks++; if (r_wecnt !== 0) begin errors++; $display("FAIL missh_writes: got %0d expected 0", r_wecnt); end
    checks++; if (mem[16] !== 32'h4433_2211) begin errors++; $display("FAIL missh_word: got %h expected 44332211", mem[16]); end
    do_req(1'b0, F3_LW, 32'h42, 32'h0);
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL mislw2_err: got %b expected 1", r_err); end
    do_req(1'b0, F3_LH, 32'h42, 32'h0);
    checks++; if (r_err !== 1'b0 || r_rdata !== 32'h0000_4433) begin errors++; $display("FAIL lh_aligned: got err=%b %h expected err=0 00004433", r_err, r_rdata); end
    checks++; if (r_lat !== 2) begin errors++; $display("FAIL lh_aligned_latency: got %0d expected 2", r_lat); end
`endif
  endtask

  task automatic test_wrap();
`ifdef LSU_MISALIGN_EN
    poke(10'h3FF, 32'h1111_1111);
    poke(10'h000, 32'h2222_2222);
    do_req(1'b1, F3_SH, 32'hFFF, 32'h0000_CAFE);
    checks++; if (r_wa[0] !== 10'h3FF || r_wa[1] !== 10'h000) begin errors++; $display("FAIL wrap_addrs: got %h,%h expected 3ff,000", r_wa[0], r_wa[1]); end
    checks++; if (mem[1023] !== 32'hFE11_1111) begin errors++; $display("FAIL wrap_word0: got %h expected fe111111", mem[1023]); end
    checks++; if (mem[0] !== 32'h2222_22CA) begin errors++; $display("FAIL wrap_word1: got %h expected 222222ca", mem[0]); end
    do_req(1'b0, F3_LH, 32'hFFF, 32'h0);
    checks++; if (r_rdata !== 32'hFFFF_CAFE) begin errors++; $display("FAIL wrap_lh: got %h expected ffffcafe", r_rdata); end
    checks++; if (r_lat !== 3) begin errors++; $display("FAIL wrap_lh_latency: got %0d expected 3", r_lat); end
`else
    poke(10'h3FF, 32'h1111_1111);
    do_req(1'b1, F3_SB, 32'hFFF, 32'h0000_0077);
    checks++; if (r_wa[0] !== 10'h3FF) begin errors++; $display("FAIL top_sb_addr: got %h expected 3ff", r_wa[0]); end
    checks++; if (mem[1023] !== 32'h7711_1111) begin errors++; $display("FAIL top_sb_word: got %h expected 77111111", mem[1023]); end
    do_req(1'b0, F3_LBU, 32'hFFF, 32'h0);
    checks++; if (r_rdata !== 32'h0000_0077) begin errors++; $display("FAIL top_lbu: got %h expected 00000077", r_rdata); end
    do_req(1'b0, F3_LW, 32'hFFC, 32'h0);
    checks++; if (r_rdata !== 32'h7711_1111) begin errors++; $display("FAIL top_lw: got %h expected 77111111", r_rdata); end
`endif
  endtask

  task automatic test_reset_midop();
    poke(10'h012, 32'h1234_5678);
`ifdef LSU_MISALIGN_EN
    start_req(1'b1, F3_SW, 32'h45, 32'hA5A5_A5A5);
`else
    start_req(1'b1, F3_SB, 32'h50, 32'h0000_00A5);
`endif
    @(negedge CLK);
    @(negedge CLK);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL midop_in_wr0: got mem_we=%b expected 1", mem_we); end
    #1 RST = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midop_req_ready: got %b expected 1", req_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midop_mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 10'h0 || mem_wd !== 32'h0) begin errors++; $display("FAIL midop_mem_port: got %h/%h expected 0/0", mem_addr, mem_wd); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL midop_resp: got %b/%b/%h expected 0/0/0", resp_valid, resp_err, resp_rdata); end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    checks++; if (mem[18] !== 32'h1234_5678) begin errors++; $display("FAIL midop_word1: got %h expected 12345678", mem[18]); end
    do_req(1'b0, F3_LW, 32'h48, 32'h0);
    checks++; if (r_rdata !== 32'h1234_5678 || r_lat !== 2) begin errors++; $display("FAIL post_reset_lw: got %h lat %0d expected 12345678 lat 2", r_rdata, r_lat); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int wcnt;
    logic [31:0] got;
    start_req(1'b0, F3_LW, 32'h48, 32'h0);
    // Present a conflicting store while busy; it must be ignored.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW; req_addr = 32'h4C; req_wdata = 32'hFFFF_FFFF;
    lat = -1; wcnt = 0; got = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (mem_we) wcnt++;
      if (resp_valid) begin lat = c; got = resp_rdata; break; end
    end
    req_valid = 1'b0;
    checks++; if (got !== 32'h1234_5678 || lat !== 2) begin errors++; $display("FAIL busy_lw: got %h lat %0d expected 12345678 lat 2", got, lat); end
    checks++; if (wcnt !== 0) begin errors++; $display("FAIL busy_ignored_writes: got %0d expected 0", wcnt); end
    @(negedge CLK);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_pulse: got %b expected 0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_resp: got %b expected 1", req_ready); end
    checks++; if (mem[19] !== 32'h0BAD_F00D) begin errors++; $display("FAIL busy_store_leak: got %h expected 0badf00d", mem[19]); end
    do_req(1'b1, F3_SB, 32'h4D, 32'h0000_0011);
    do_req(1'b0, F3_LHU, 32'h4C, 32'h0);
    checks++; if (r_rdata !== 32'h0000_110D) begin errors++; $display("FAIL b2b_lhu: got %h expected 0000110d", r_rdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(posedge CLK);
    test_reset();
    test_load();
    test_store();
    test_error();
    test_misalign();
    test_wrap();
    test_reset_midop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute/memory stage and DataMemory.
- Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW byte-addressed requests into word accesses on DataMemory's port set: word address, write data, write enable, and combinational read data.
- Sub-word stores become read-modify-write sequences. Loads are extracted and sign- or zero-extended.
- Uses a valid/ready request handshake and a single-cycle response pulse toward the core.

Parameters:
- REG_BITS, 32, data and byte-address width.
- MEM_ADDR_BITS, 10, word-address width of DataMemory (2^10 words).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  reset; asynchronous, active-high.
- req_valid  input  1  core presents a request.
- req_ready  output  1  high only in IDLE; a request is accepted on a posedge with req_valid&req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3. [1:0]: 00 byte, 01 half, 10 word, 11 illegal. [2]: unsigned load.
- req_addr  input  REG_BITS  byte address.
- req_wdata  input  REG_BITS  store data, low bytes used for sub-word stores.
- resp_valid  output  1  one-cycle pulse when the operation completes.
- resp_rdata  output  REG_BITS  extended load data, valid with resp_valid; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid; illegal size, or misaligned access when the feature is off.
- mem_addr  output  MEM_ADDR_BITS  word address to DataMemory.
- mem_wd  output  REG_BITS  write data to DataMemory.
- mem_we  output  1  write enable to DataMemory.
- mem_rd  input  REG_BITS  combinational read data from DataMemory.

Behaviour:
- Request capture:
  - On accept, register we, funct3, addr and wdata.
  - word0 = addr[MEM_ADDR_BITS+1:2]; off = addr[1:0].
  - Upper address bits are ignored (memory aliases).
- A request crosses a word boundary when off + size_bytes > 4:
  - half at off 3;
  - word at off 1..3.
  - word1 = word0+1, wrapping modulo 2^MEM_ADDR_BITS.
- FSM states: IDLE, RD0, WR0, RD1, WR1, RESP.
  - IDLE → RESP on an illegal request, error path.
  - Aligned-in-word load: IDLE → RD0 → RESP. RD0 drives word0 and captures mem_rd.
  - Full word store at off 0: IDLE → WR0 → RESP. WR0 writes wdata directly.
  - Sub-word store within one word: IDLE → RD0 → WR0 → RESP. WR0 writes mem_rd with the addressed lanes replaced.
  - Crossing load: IDLE → RD0 → RD1 → RESP.
  - Crossing store: IDLE → RD0 → WR0 → RD1 → WR1 → RESP.
  - RESP → IDLE unconditionally. resp_valid=1 only in RESP.
- Latency from the accept edge to the resp_valid cycle:
  - aligned load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - crossing load: 3 cycles;
  - crossing store: 5 cycles;
  - error: 1 cycle.
- Memory-side outputs:
  - mem_we is high only in WR0/WR1, exactly one cycle each.
  - mem_addr = word0 in IDLE/RD0/WR0/RESP, word1 in RD1/WR1.
  - mem_wd = 0 outside WR states.
- Load extraction: byte and half data are taken from the lane(s) at off, little-endian. Sign-extend when funct3[2]=0, zero-extend otherwise.
- Request inputs are ignored while req_ready=0.
- Reset, including mid-operation:
  - state → IDLE, req_ready=1;
  - resp_valid=0, resp_err=0, resp_rdata=0;
  - mem_we=0, mem_addr=0, mem_wd=0.
  - A WR0 already committed before reset stays in memory; no rollback.

Optional Feature:
- Macro LSU_MISALIGN_EN.
- Defined: crossing accesses are split as described above.
- Undefined:
  - any access with off not a multiple of its size returns resp_err=1 and resp_rdata=0 after 1 cycle;
  - no memory write occurs;
  - RD1/WR1 are not synthesized.
- Illegal size (funct3[1:0]=11) is an error in both builds.

Decomposition:
- Package lsu_pkg:
  - size enum (SZ_B, SZ_H, SZ_W);
  - state enum;
  - funct3 constants (F3_LB..F3_SW);
  - function size_bytes.
- Sub-module lsu_align, combinational:
  - load_extract(lo_word, hi_word, off, size, unsigned) → REG_BITS;
  - store_merge(old_word, wdata, off, size, part) → merged word plus lane mask.
  - part selects the low or high word.

Test Plan:
- Preload word 0x10 = 0x8899AABB. LB addr 0x41 → resp_rdata 0xFFFFFFAA after 2 cycles; LBU → 0x000000AA.
- SB 0x5C to addr 0x42 → mem_we one cycle with mem_addr 0x10, mem_wd 0x885CAABB; resp_valid 3 cycles after accept.
- LSU_MISALIGN_EN defined, word 0x10 = 0x44332211, word 0x11 = 0x88776655. LW addr 0x43 → 0x77665544 in 3 cycles.
  - Same build, SH 0xBEEF at addr 0x43 → word 0x10 = 0xEF332211, word 0x11 = 0x887766BE.
- LSU_MISALIGN_EN undefined: LW addr 0x43 → resp_err=1, resp_rdata=0, mem_we never asserted.
- Wrap (LSU_MISALIGN_EN defined): SH at byte addr 0xFFF (word 0x3FF, off 3) → writes word 0x3FF then word 0x000.
- Assert RST during WR0 of a crossing store → all outputs 0 immediately, req_ready=1, word1 unchanged; the next request is accepted normally.
